// File: rtl/arm_regfile_pkg.sv
// ============================================================================
// Module      : arm_regfile_pkg
// Description : Shared defaults, write-source encoding and port-vector helpers
//               for the multi-port ARM register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_regfile_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_ADDR_W    = 4;
    localparam int DEFAULT_NUM_RD    = 3;
    localparam int DEFAULT_PC_IDX    = 15;
    localparam int DEFAULT_PC_OFFSET = 8;
    localparam int DEFAULT_NREG      = 2**DEFAULT_ADDR_W;

    typedef enum logic [1:0] {
        WR_SRC_NONE = 2'd0,
        WR_SRC_P0   = 2'd1,
        WR_SRC_P1   = 2'd2
    } wr_src_e;

    // Helpers sized for the default geometry, for decode-side users.
    function automatic logic [DEFAULT_NREG-1:0] reg_onehot(input logic [DEFAULT_ADDR_W-1:0] addr);
        logic [DEFAULT_NREG-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

    function automatic logic [DEFAULT_ADDR_W-1:0] unpack_addr(
        input logic [DEFAULT_NUM_RD*DEFAULT_ADDR_W-1:0] vec,
        input int unsigned                             port
    );
        return vec[port*DEFAULT_ADDR_W +: DEFAULT_ADDR_W];
    endfunction

    function automatic logic [DEFAULT_NUM_RD*DEFAULT_DATA_W-1:0] pack_data(
        input logic [DEFAULT_DATA_W-1:0] data [DEFAULT_NUM_RD]
    );
        logic [DEFAULT_NUM_RD*DEFAULT_DATA_W-1:0] v;
        for (int k = 0; k < DEFAULT_NUM_RD; k++) begin
            v[k*DEFAULT_DATA_W +: DEFAULT_DATA_W] = data[k];
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arm_regfile_scoreboard.sv
// ============================================================================
// Module      : arm_regfile_scoreboard
// Description : Pending-write scoreboard and read-stall generation.
//               Macro ARM_REGFILE_BYPASS_EN releases a stall in the write cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_regfile_scoreboard
    import arm_regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    parameter int PC_IDX = DEFAULT_PC_IDX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic                     rd_stall
);

    localparam int c_NREG = 2**ADDR_W;

    logic [c_NREG-1:0] w_written;
    logic [c_NREG-1:0] w_claim;
    logic [c_NREG-1:0] r_pending;
    logic              w_stall;

    always_comb begin
        w_written = '0;
        w_claim   = '0;
        for (int r = 0; r < c_NREG; r++) begin
            w_written[r] = (wr_en0 && (wr_addr0 == ADDR_W'(r))) ||
                           (wr_en1 && (wr_addr1 == ADDR_W'(r)));
            w_claim[r]   = claim_en && (claim_addr == ADDR_W'(r)) && (r != PC_IDX);
        end
    end

    // A claim landing with a write keeps the bit set: the new load is the producer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_written) | w_claim;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
`ifdef ARM_REGFILE_BYPASS_EN
            w_stall = w_stall | (r_pending[rd_addr[k*ADDR_W +: ADDR_W]] &
                                 ~w_written[rd_addr[k*ADDR_W +: ADDR_W]]);
`else
            w_stall = w_stall | r_pending[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign pending  = r_pending;
    assign rd_stall = w_stall;

endmodule

`default_nettype wire

// File: rtl/arm_regfile_mp.sv
// ============================================================================
// Module      : arm_regfile_mp
// Description : Multi-port ARM register file: NUM_RD reads, two writes, PC
//               mapping and load-use scoreboard. Macro ARM_REGFILE_BYPASS_EN
//               enables same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_regfile_mp
    import arm_regfile_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int NUM_RD    = DEFAULT_NUM_RD,
    parameter int PC_IDX    = DEFAULT_PC_IDX,
    parameter int PC_OFFSET = DEFAULT_PC_OFFSET
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0]        pc_in,
    output logic                     pc_wr,
    output logic [DATA_W-1:0]        pc_wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic                     rd_stall
);

    localparam int                c_NREG    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_ADDR = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] w_rf [c_NREG];
    logic [DATA_W-1:0] w_pc_value;
    logic              w_wr0_pc;
    logic              w_wr1_pc;
    wr_src_e           w_pc_src;
    logic [DATA_W-1:0] w_pc_data;

    assign w_pc_value = pc_in + DATA_W'(PC_OFFSET);
    assign w_wr0_pc   = wr_en0 && (wr_addr0 == c_PC_ADDR);
    assign w_wr1_pc   = wr_en1 && (wr_addr1 == c_PC_ADDR);

    always_comb begin
        w_pc_src = WR_SRC_NONE;
        if (w_wr0_pc) begin
            w_pc_src = WR_SRC_P0;
        end else if (w_wr1_pc) begin
            w_pc_src = WR_SRC_P1;
        end
    end

    always_comb begin
        case (w_pc_src)
            WR_SRC_P0: w_pc_data = wr_data0;
            WR_SRC_P1: w_pc_data = wr_data1;
            default:   w_pc_data = '0;
        endcase
    end

    assign pc_wr      = (w_pc_src != WR_SRC_NONE);
    assign pc_wr_data = w_pc_data;

    // The PC slot has no storage; its read view is the fetch PC plus offset.
    for (genvar r = 0; r < c_NREG; r++) begin : g_reg
        if (r == PC_IDX) begin : g_pc
            assign w_rf[r] = w_pc_value;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            logic              w_hit0;
            logic              w_hit1;

            assign w_hit0 = wr_en0 && (wr_addr0 == ADDR_W'(r));
            assign w_hit1 = wr_en1 && (wr_addr1 == ADDR_W'(r));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_q <= '0;
                end else if (w_hit0) begin
                    r_q <= wr_data0;
                end else if (w_hit1) begin
                    r_q <= wr_data1;
                end
            end

            assign w_rf[r] = r_q;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef ARM_REGFILE_BYPASS_EN
        always_comb begin
            w_data = w_rf[w_addr];
            if (w_addr != c_PC_ADDR) begin
                if (wr_en0 && (wr_addr0 == w_addr)) begin
                    w_data = wr_data0;
                end else if (wr_en1 && (wr_addr1 == w_addr)) begin
                    w_data = wr_data1;
                end
            end
        end
`else
        assign w_data = w_rf[w_addr];
`endif

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
    end

    arm_regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .PC_IDX (PC_IDX)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en0     (wr_en0),
        .wr_addr0   (wr_addr0),
        .wr_en1     (wr_en1),
        .wr_addr1   (wr_addr1),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr    (rd_addr),
        .pending    (pending),
        .rd_stall   (rd_stall)
    );

endmodule

`default_nettype wire
